axicb_burst_arbiter: RTL and testbench



---
 rtl/axicb_pkg.sv | 13 +
 rtl/axicb_rr_level_select.sv | 33 +++
 rtl/axicb_burst_arbiter.sv | 116 +++++++++++
 tb/tb_axicb_burst_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axicb_pkg.sv
// Shared types and constants for the crossbar burst arbiter.
// Priority levels are 2-bit; level 3 wins over level 0.
package axicb_pkg;

  localparam int PRIO_W   = 2;
  localparam int PRIO_LVL = 4;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/axicb_rr_level_select.sv
// Round-robin pick within one priority level: lowest masked requester,
// falling back to the lowest unmasked one; also returns the rotated mask.
module axicb_rr_level_select #(
  parameter int REQ_NB = 4
) (
  input  logic [REQ_NB-1:0] req,
  input  logic [REQ_NB-1:0] mask,
  output logic [REQ_NB-1:0] pick,
  output logic [REQ_NB-1:0] next_mask
);

  logic [REQ_NB-1:0] cand;
  logic [REQ_NB-1:0] src;
  logic              found;

  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    pick      = '0;
    next_mask = mask;
    found     = 1'b0;
    cand      = req & mask;
    src       = (|cand) ? cand : req;
    for (int i = 0; i < REQ_NB; i++) begin
      if (src[i] && !found) begin
        found   = 1'b1;
        pick[i] = 1'b1;
        // Only requesters above the winner stay eligible; the top one re-opens the whole level.
        next_mask = (i == REQ_NB - 1) ? '1 : ({REQ_NB{1'b1}} << (i + 1));
      end
    end
  end

endmodule

// File: rtl/axicb_burst_arbiter.sv
// Priority-aware round-robin arbiter that locks one requester onto the shared
// valid/ready/last channel until its last-beat handshake.
module axicb_burst_arbiter
  import axicb_pkg::*;
#(
  parameter int                         REQ_NB = 4,
  parameter int                         DATA_W = 8,
  parameter logic [REQ_NB*PRIO_W-1:0]   PRIO   = '0
) (
  input  logic                     aclk,
  input  logic                     srst,
  input  logic [REQ_NB-1:0]        req_valid,
  input  logic [REQ_NB-1:0]        req_last,
  input  logic [REQ_NB*DATA_W-1:0] req_data,
  output logic [REQ_NB-1:0]        req_ready,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [REQ_NB-1:0]        grant,
  output logic                     busy
);

  arb_state_t                       state_q, state_d;
  logic [REQ_NB-1:0]                grant_q, grant_d;
  logic [PRIO_LVL-1:0][REQ_NB-1:0]  mask_q, mask_d;
  logic [PRIO_LVL-1:0][REQ_NB-1:0]  lvl_member;
  logic [PRIO_LVL-1:0][REQ_NB-1:0]  lvl_req;
  logic [PRIO_LVL-1:0][REQ_NB-1:0]  lvl_pick;
  logic [PRIO_LVL-1:0][REQ_NB-1:0]  lvl_next_mask;
  logic [PRIO_W-1:0]                top_lvl;
  logic                             locked;
  logic                             hs;

  for (genvar l = 0; l < PRIO_LVL; l++) begin : g_lvl
    for (genvar i = 0; i < REQ_NB; i++) begin : g_req
      assign lvl_member[l][i] = (PRIO[PRIO_W*i +: PRIO_W] == PRIO_W'(l));
    end
    assign lvl_req[l] = req_valid & lvl_member[l];

    axicb_rr_level_select #(.REQ_NB(REQ_NB)) u_sel (
      .req       (lvl_req[l]),
      .mask      (mask_q[l]),
      .pick      (lvl_pick[l]),
      .next_mask (lvl_next_mask[l])
    );
  end

  // Highest level that has at least one valid requester.
  always_comb begin
    top_lvl = '0;
    for (int l = 0; l < PRIO_LVL; l++) begin
      if (|lvl_req[l]) top_lvl = PRIO_W'(l);
    end
  end

  assign locked = (state_q == LOCKED);
  assign grant  = grant_q;
  assign busy   = locked;

  // One-hot grant makes the mux an OR of the selected lane; idle gives all zeros.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    if (locked) begin
      for (int i = 0; i < REQ_NB; i++) begin
        if (grant_q[i]) begin
          out_valid = req_valid[i];
          out_last  = req_last[i];
          out_data  = req_data[DATA_W*i +: DATA_W];
        end
      end
    end
    if (srst) out_valid = 1'b0;
  end

  assign req_ready = (locked && !srst) ? (grant_q & {REQ_NB{out_ready}}) : '0;
  assign hs        = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d         = LOCKED;
          grant_d         = lvl_pick[top_lvl];
          mask_d[top_lvl] = lvl_next_mask[top_lvl];
        end
      end
      LOCKED: begin
        if (hs && out_last) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q <= IDLE;
      grant_q <= '0;
      // NOTE: the masks are reset to all ones so every level restarts its rotation at index 0.
      mask_q  <= '1;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_axicb_burst_arbiter.sv
// Bench for axicb_burst_arbiter: an equal-priority instance and one with req2 at level 2,
// both checked every cycle against a pointer-based round-robin model.
module tb_axicb_burst_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int OBS_W = N + 1 + 1 + 1 + DW + N;
  localparam logic [2*N-1:0] PRIO_PR = 8'b00_10_00_00;

  logic            aclk = 1'b0;
  logic            srst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic            out_ready;

  logic [1:0][N-1:0]     req_ready_o;
  logic [1:0][N-1:0]     grant_o;
  logic [1:0]            out_valid_o;
  logic [1:0]            out_last_o;
  logic [1:0]            busy_o;
  logic [1:0][DW-1:0]    out_data_o;
  logic [1:0][OBS_W-1:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: k=0 equal priority, k=1 req2 at level 2.
  int m_prio   [2][N];
  bit m_locked [2];
  int m_g      [2];
  int m_ptr    [2][4];

  always #5 aclk = ~aclk;

  axicb_burst_arbiter #(.REQ_NB(N), .DATA_W(DW), .PRIO('0)) dut_eq (
    .aclk(aclk), .srst(srst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready_o[0]), .out_valid(out_valid_o[0]),
    .out_last(out_last_o[0]), .out_data(out_data_o[0]), .out_ready(out_ready),
    .grant(grant_o[0]), .busy(busy_o[0])
  );

  axicb_burst_arbiter #(.REQ_NB(N), .DATA_W(DW), .PRIO(PRIO_PR)) dut_pr (
    .aclk(aclk), .srst(srst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready_o[1]), .out_valid(out_valid_o[1]),
    .out_last(out_last_o[1]), .out_data(out_data_o[1]), .out_ready(out_ready),
    .grant(grant_o[1]), .busy(busy_o[1])
  );

  for (genvar k = 0; k < 2; k++) begin : g_obs
    assign obs[k] = {grant_o[k], busy_o[k], out_valid_o[k], out_last_o[k], out_data_o[k], req_ready_o[k]};
  end

  function automatic logic [OBS_W-1:0] exp_obs(int k);
    logic [N-1:0]  g;
    logic [N-1:0]  rdy;
    logic          ov;
    logic          ol;
    logic [DW-1:0] od;
    g = '0; rdy = '0; ov = 1'b0; ol = 1'b0; od = '0;
    if (m_locked[k]) begin
      g[m_g[k]] = 1'b1;
      ov        = req_valid[m_g[k]] && !srst;
      ol        = req_last[m_g[k]];
      od        = req_data[m_g[k]*DW +: DW];
      if (!srst) rdy[m_g[k]] = out_ready;
    end
    return {g, m_locked[k], ov, ol, od, rdy};
  endfunction

  // Clock-edge update: highest valid level wins, rotation resumes after the last winner of that level.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (srst) begin
        m_locked[k] = 1'b0;
        for (int lv = 0; lv < 4; lv++) m_ptr[k][lv] = -1;
      end else if (m_locked[k]) begin
        if (req_valid[m_g[k]] && out_ready && req_last[m_g[k]]) m_locked[k] = 1'b0;
      end else if (|req_valid) begin
        int lvl;
        int pick;
        lvl  = -1;
        pick = -1;
        for (int i = 0; i < N; i++)
          if (req_valid[i] && m_prio[k][i] > lvl) lvl = m_prio[k][i];
        for (int i = m_ptr[k][lvl] + 1; i < N; i++)
          if (pick < 0 && req_valid[i] && m_prio[k][i] == lvl) pick = i;
        for (int i = 0; i < N; i++)
          if (pick < 0 && req_valid[i] && m_prio[k][i] == lvl) pick = i;
        m_locked[k]   = 1'b1;
        m_g[k]        = pick;
        m_ptr[k][lvl] = pick;
      end
    end
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] l, input logic r, input logic rst);
    req_valid = v;
    req_last  = l;
    out_ready = r;
    srst      = rst;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    #1;
  endtask

  task automatic advance();
    @(posedge aclk);
    model_edge();
    @(negedge aclk);
    #1;
  endtask

  task automatic do_reset();
    set_in('0, '0, 1'b0, 1'b1);
    advance();
  endtask

  task automatic test_reset();
    set_in(N'($urandom), N'($urandom), 1'($urandom), 1'b1);
    advance();
    set_in(N'($urandom), N'($urandom), 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({grant_o[k], busy_o[k], out_valid_o[k], req_ready_o[k]} !== '0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d grant=%b busy=%b out_valid=%b req_ready=%b want all 0",
                 k, grant_o[k], busy_o[k], out_valid_o[k], req_ready_o[k]);
      end
      n_cmp++;
      if (obs[k] !== exp_obs(k)) begin
        n_bad++;
        $display("FAIL reset_model dut%0d got=%h want=%h", k, obs[k], exp_obs(k));
      end
    end
    advance();
  endtask

  task automatic test_rr_single_beat();
    logic [N-1:0] seq [5];
    logic [N-1:0] want;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int t = 0; t < 10; t++) begin
      set_in(4'hF, 4'hF, 1'b1, 1'b0);
      want = (t % 2 == 1) ? seq[t/2] : '0;
      n_cmp++;
      if (grant_o[0] !== want) begin
        n_bad++;
        $display("FAIL rr_seq cyc%0d grant=%b want=%b", t, grant_o[0], want);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs[k] !== exp_obs(k)) begin
          n_bad++;
          $display("FAIL rr_model dut%0d cyc%0d got=%h want=%h", k, t, obs[k], exp_obs(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_burst_lock();
    logic [4:0]   rdy_pat;
    logic [N-1:0] want [9];
    logic         rdy;
    int           beats;
    rdy_pat = 5'b11101;
    want    = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    beats   = 0;
    do_reset();
    for (int t = 0; t < 9; t++) begin
      rdy = (t >= 1 && t <= 5) ? rdy_pat[t-1] : 1'b1;
      set_in(4'b0011, {3'b111, (beats == 3)}, rdy, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (grant_o[k] !== want[t]) begin
          n_bad++;
          $display("FAIL burst_lock dut%0d cyc%0d grant=%b want=%b", k, t, grant_o[k], want[t]);
        end
        n_cmp++;
        if (obs[k] !== exp_obs(k)) begin
          n_bad++;
          $display("FAIL burst_model dut%0d cyc%0d got=%h want=%h", k, t, obs[k], exp_obs(k));
        end
      end
      if (t >= 1 && t <= 5 && rdy) beats++;
      advance();
    end
  endtask

  task automatic test_priority();
    logic [N-1:0] want [12];
    want = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100,
             4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b1000};
    do_reset();
    for (int t = 0; t < 12; t++) begin
      set_in((t <= 5) ? 4'b1111 : 4'b1011, 4'hF, 1'b1, 1'b0);
      n_cmp++;
      if (grant_o[1] !== want[t]) begin
        n_bad++;
        $display("FAIL priority cyc%0d grant=%b want=%b", t, grant_o[1], want[t]);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs[k] !== exp_obs(k)) begin
          n_bad++;
          $display("FAIL prio_model dut%0d cyc%0d got=%h want=%h", k, t, obs[k], exp_obs(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_mask_fallback();
    logic [N-1:0] want [6];
    want = '{4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
    do_reset();
    for (int t = 0; t < 6; t++) begin
      set_in((t == 0) ? 4'b0010 : 4'b0011, 4'hF, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (grant_o[k] !== want[t]) begin
          n_bad++;
          $display("FAIL mask_fallback dut%0d cyc%0d grant=%b want=%b", k, t, grant_o[k], want[t]);
        end
        n_cmp++;
        if (obs[k] !== exp_obs(k)) begin
          n_bad++;
          $display("FAIL fallback_model dut%0d cyc%0d got=%h want=%h", k, t, obs[k], exp_obs(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] want [8];
    logic         stall;
    logic         rdy;
    want = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    do_reset();
    for (int t = 0; t < 8; t++) begin
      stall = (t >= 2 && t <= 4);
      rdy   = stall ? 1'($urandom) : 1'b1;
      set_in(stall ? 4'b1110 : 4'b1111, {3'b111, (t >= 5)}, rdy, 1'b0);
      n_cmp++;
      if (grant_o[0] !== want[t]) begin
        n_bad++;
        $display("FAIL stall_grant cyc%0d grant=%b want=%b", t, grant_o[0], want[t]);
      end
      if (stall) begin
        n_cmp++;
        if ({out_valid_o[0], req_ready_o[0]} !== {1'b0, 3'b000, rdy}) begin
          n_bad++;
          $display("FAIL stall_ready cyc%0d out_valid=%b req_ready=%b want 0 / %b",
                   t, out_valid_o[0], req_ready_o[0], {3'b000, rdy});
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs[k] !== exp_obs(k)) begin
          n_bad++;
          $display("FAIL stall_model dut%0d cyc%0d got=%h want=%h", k, t, obs[k], exp_obs(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [N-1:0] want [2][5];
    want[0] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    want[1] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
    do_reset();
    for (int t = 0; t < 5; t++) begin
      set_in(4'hF, 4'h0, 1'b1, (t == 2));
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (grant_o[k] !== want[k][t]) begin
          n_bad++;
          $display("FAIL midrst_grant dut%0d cyc%0d grant=%b want=%b", k, t, grant_o[k], want[k][t]);
        end
        if (t == 2 || t == 3) begin
          n_cmp++;
          if ({out_valid_o[k], req_ready_o[k]} !== '0 || busy_o[k] !== (t == 2)) begin
            n_bad++;
            $display("FAIL midrst_out dut%0d cyc%0d out_valid=%b req_ready=%b busy=%b want 0/0/%b",
                     k, t, out_valid_o[k], req_ready_o[k], busy_o[k], (t == 2));
          end
        end
        n_cmp++;
        if (obs[k] !== exp_obs(k)) begin
          n_bad++;
          $display("FAIL midrst_model dut%0d cyc%0d got=%h want=%h", k, t, obs[k], exp_obs(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] l;
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 2) == 0);
      set_in(N'($urandom), l, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs[k] !== exp_obs(k)) begin
          n_bad++;
          $display("FAIL random_model dut%0d cyc%0d got=%h want=%h", k, t, obs[k], exp_obs(k));
        end
      end
      advance();
    end
  endtask

  initial begin
    srst      = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_locked[k] = 1'b0;
      m_g[k]      = 0;
      for (int lv = 0; lv < 4; lv++) m_ptr[k][lv] = -1;
      for (int i = 0; i < N; i++) m_prio[k][i] = (k == 1 && i == 2) ? 2 : 0;
    end
    @(negedge aclk);
    #1;
    test_reset();
    test_rr_single_beat();
    test_burst_lock();
    test_priority();
    test_mask_fallback();
    test_stall();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
